sx3_i2c_cfg_target: RTL

//  I2C target (responder) for SX3 master on sx3_i2c_scl/sda; clk_osc domain register bank.

---
 rtl/sx3_cfg_pkg.sv | 40 ++++
 rtl/i2c_line_filter.sv | 49 ++++
 rtl/sx3_i2c_cfg_target.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sx3_cfg_pkg.sv
// Register map, CTRL bit positions and FSM encoding shared by the SX3 I2C config target.
package sx3_cfg_pkg;

  localparam logic [7:0] REG_ID       = 8'h00;
  localparam logic [7:0] REG_CTRL     = 8'h01;
  localparam logic [7:0] REG_WT_LO    = 8'h02;
  localparam logic [7:0] REG_WT_HI    = 8'h03;
  localparam logic [7:0] REG_HT_LO    = 8'h04;
  localparam logic [7:0] REG_HT_HI    = 8'h05;
  localparam logic [7:0] REG_SIZE0    = 8'h06;
  localparam logic [7:0] REG_SIZE1    = 8'h07;
  localparam logic [7:0] REG_SIZE2    = 8'h08;
  localparam logic [7:0] REG_SIZE3    = 8'h09;
  localparam logic [7:0] REG_FPS      = 8'h0A;
  localparam logic [7:0] REG_BLANK_LO = 8'h0B;
  localparam logic [7:0] REG_BLANK_HI = 8'h0C;
  localparam logic [7:0] REG_STATUS   = 8'h0D;

  localparam int unsigned CTRL_CAM_EN   = 0;
  localparam int unsigned CTRL_AUD_EN   = 1;
  localparam int unsigned CTRL_STILL_EN = 2;
  localparam int unsigned CTRL_VID_RST  = 3;
  localparam int unsigned CTRL_AUD_RST  = 4;
  localparam int unsigned CTRL_OVF_CLR  = 5;

  localparam logic [7:0] DEF_FPS = 8'd30;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises one I2C pad into clk_osc, rejects glitches shorter than FILT_LEN cycles,
// and produces single-cycle rise/fall strobes aligned with the filtered level.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk_osc,
  input  logic reset_n_HFCLKOUT,
  input  logic pad_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       prev_q, prev_d;

  // The filtered level only follows the synchronised input after FILT_LEN agreeing cycles.
  always_comb begin
    sync_d = {sync_q[0], pad_i};
    filt_d = filt_q;
    cnt_d  = '0;
    prev_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == 3'(FILT_LEN - 1)) filt_d = sync_q[1];
      else                           cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
    if (!reset_n_HFCLKOUT) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
    end
  end

  assign line_o = filt_q;
  assign rise_o = filt_q & ~prev_q;
  assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/sx3_i2c_cfg_target.sv
// I2C configuration target for the SX3 master: shadow register bank committed to the
// clk_osc control/geometry outputs on STOP, so multi-byte fields change atomically.
module sx3_i2c_cfg_target #(
  parameter logic [6:0]  I2C_ADDR = 7'h38,
  parameter int unsigned FILT_LEN = 3,
  parameter logic [7:0]  DEV_ID   = 8'hA5,
  parameter logic [15:0] DEF_WT   = 16'd1920,
  parameter logic [15:0] DEF_HT   = 16'd1280,
  parameter logic [31:0] DEF_SIZE = 32'd2457600
) (
  input  logic        clk_osc,
  input  logic        reset_n_HFCLKOUT,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic        cam_fifo_overflow_i,
  output logic        cam_app_en_o,
  output logic        aud_app_en_o,
  output logic        still_cap_en_o,
  output logic        vid_skt_rst_o,
  output logic        aud_skt_rst_o,
  output logic [15:0] img_wt_o,
  output logic [15:0] img_ht_o,
  output logic [31:0] img_size_o,
  output logic [7:0]  vid_fps_o,
  output logic [15:0] line_blanking_o,
  output logic        busy_o
);
  import sx3_cfg_pkg::*;

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall, start, stop;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_osc(clk_osc), .reset_n_HFCLKOUT(reset_n_HFCLKOUT), .pad_i(scl_i),
    .line_o(scl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_osc(clk_osc), .reset_n_HFCLKOUT(reset_n_HFCLKOUT), .pad_i(sda_i),
    .line_o(sda), .rise_o(sda_rise), .fall_o(sda_fall));

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, ptr_q, ptr_d, rd_byte;
  logic        rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, mack_q, mack_d;
  logic        commit_q, commit_d, wr_en;
  logic [2:0]  shd_ctrl_q, shd_ctrl_d, ctrl_q, ctrl_d;
  logic        pend_vid_q, pend_vid_d, pend_aud_q, pend_aud_d, pend_clr_q, pend_clr_d;
  logic [15:0] shd_wt_q, shd_wt_d, shd_ht_q, shd_ht_d, shd_blank_q, shd_blank_d;
  logic [15:0] wt_q, wt_d, ht_q, ht_d, blank_q, blank_d;
  logic [31:0] shd_size_q, shd_size_d, size_q, size_d;
  logic [7:0]  shd_fps_q, shd_fps_d, fps_q, fps_d;
  logic        vid_rst_q, vid_rst_d, aud_rst_q, aud_rst_d, ovf_q, ovf_d;
  logic [1:0]  ovf_sync_q, ovf_sync_d;

  always_comb begin
    case (ptr_q)
      REG_ID:       rd_byte = DEV_ID;
      REG_CTRL:     rd_byte = {5'b0, shd_ctrl_q};
      REG_WT_LO:    rd_byte = shd_wt_q[7:0];
      REG_WT_HI:    rd_byte = shd_wt_q[15:8];
      REG_HT_LO:    rd_byte = shd_ht_q[7:0];
      REG_HT_HI:    rd_byte = shd_ht_q[15:8];
      REG_SIZE0:    rd_byte = shd_size_q[7:0];
      REG_SIZE1:    rd_byte = shd_size_q[15:8];
      REG_SIZE2:    rd_byte = shd_size_q[23:16];
      REG_SIZE3:    rd_byte = shd_size_q[31:24];
      REG_FPS:      rd_byte = shd_fps_q;
      REG_BLANK_LO: rd_byte = shd_blank_q[7:0];
      REG_BLANK_HI: rd_byte = shd_blank_q[15:8];
      REG_STATUS:   rd_byte = {7'b0, ovf_q};
      default:      rd_byte = '0;
    endcase
  end

  // Bus FSM: bits sampled on SCL rise, SDA driven/released just after SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    mack_d    = mack_q;
    commit_d  = stop;
    wr_en     = 1'b0;
    if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == I2C_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end else if (state_q == ST_REG) begin
              state_d = ST_REG_ACK;
              ptr_d   = shift_q;
            end else begin
              state_d = ST_WDATA_ACK;
              wr_en   = 1'b1;
              ptr_d   = ptr_q + 8'd1;
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = (state_q == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RDATA_ACK;
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = '0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = sda;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d  = ST_RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ST_IDLE;
              sda_oe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Commit clears the pending actions first, so a write landing in the same cycle is kept.
  always_comb begin
    shd_ctrl_d  = shd_ctrl_q;
    shd_wt_d    = shd_wt_q;
    shd_ht_d    = shd_ht_q;
    shd_size_d  = shd_size_q;
    shd_fps_d   = shd_fps_q;
    shd_blank_d = shd_blank_q;
    pend_vid_d  = pend_vid_q;
    pend_aud_d  = pend_aud_q;
    pend_clr_d  = pend_clr_q;
    ctrl_d      = ctrl_q;
    wt_d        = wt_q;
    ht_d        = ht_q;
    size_d      = size_q;
    fps_d       = fps_q;
    blank_d     = blank_q;
    vid_rst_d   = 1'b0;
    aud_rst_d   = 1'b0;
    ovf_sync_d  = {ovf_sync_q[0], cam_fifo_overflow_i};
    ovf_d       = ovf_q;
    if (commit_q) begin
      ctrl_d     = shd_ctrl_q;
      wt_d       = shd_wt_q;
      ht_d       = shd_ht_q;
      size_d     = shd_size_q;
      fps_d      = shd_fps_q;
      blank_d    = shd_blank_q;
      vid_rst_d  = pend_vid_q;
      aud_rst_d  = pend_aud_q;
      if (pend_clr_q) ovf_d = 1'b0;
      pend_vid_d = 1'b0;
      pend_aud_d = 1'b0;
      pend_clr_d = 1'b0;
    end
    if (ovf_sync_q[1]) ovf_d = 1'b1;
    if (wr_en) begin
      case (ptr_q)
        REG_CTRL: begin
          shd_ctrl_d = shift_q[CTRL_STILL_EN:CTRL_CAM_EN];
          if (shift_q[CTRL_VID_RST]) pend_vid_d = 1'b1;
          if (shift_q[CTRL_AUD_RST]) pend_aud_d = 1'b1;
          if (shift_q[CTRL_OVF_CLR]) pend_clr_d = 1'b1;
        end
        REG_WT_LO:    shd_wt_d[7:0]      = shift_q;
        REG_WT_HI:    shd_wt_d[15:8]     = shift_q;
        REG_HT_LO:    shd_ht_d[7:0]      = shift_q;
        REG_HT_HI:    shd_ht_d[15:8]     = shift_q;
        REG_SIZE0:    shd_size_d[7:0]    = shift_q;
        REG_SIZE1:    shd_size_d[15:8]   = shift_q;
        REG_SIZE2:    shd_size_d[23:16]  = shift_q;
        REG_SIZE3:    shd_size_d[31:24]  = shift_q;
        REG_FPS:      shd_fps_d          = shift_q;
        REG_BLANK_LO: shd_blank_d[7:0]   = shift_q;
        REG_BLANK_HI: shd_blank_d[15:8]  = shift_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
    if (!reset_n_HFCLKOUT) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      mack_q     <= 1'b1;
      commit_q   <= 1'b0;
      shd_ctrl_q <= '0;
      shd_wt_q   <= DEF_WT;
      shd_ht_q   <= DEF_HT;
      shd_size_q <= DEF_SIZE;
      shd_fps_q  <= DEF_FPS;
      shd_blank_q <= '0;
      pend_vid_q <= 1'b0;
      pend_aud_q <= 1'b0;
      pend_clr_q <= 1'b0;
      ctrl_q     <= '0;
      wt_q       <= DEF_WT;
      ht_q       <= DEF_HT;
      size_q     <= DEF_SIZE;
      fps_q      <= DEF_FPS;
      blank_q    <= '0;
      vid_rst_q  <= 1'b0;
      aud_rst_q  <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
      commit_q   <= commit_d;
      shd_ctrl_q <= shd_ctrl_d;
      shd_wt_q   <= shd_wt_d;
      shd_ht_q   <= shd_ht_d;
      shd_size_q <= shd_size_d;
      shd_fps_q  <= shd_fps_d;
      shd_blank_q <= shd_blank_d;
      pend_vid_q <= pend_vid_d;
      pend_aud_q <= pend_aud_d;
      pend_clr_q <= pend_clr_d;
      ctrl_q     <= ctrl_d;
      wt_q       <= wt_d;
      ht_q       <= ht_d;
      size_q     <= size_d;
      fps_q      <= fps_d;
      blank_q    <= blank_d;
      vid_rst_q  <= vid_rst_d;
      aud_rst_q  <= aud_rst_d;
      ovf_q      <= ovf_d;
      ovf_sync_q <= ovf_sync_d;
    end
  end

  assign sda_oe_o        = sda_oe_q;
  assign busy_o          = busy_q;
  assign cam_app_en_o    = ctrl_q[CTRL_CAM_EN];
  assign aud_app_en_o    = ctrl_q[CTRL_AUD_EN];
  assign still_cap_en_o  = ctrl_q[CTRL_STILL_EN];
  assign vid_skt_rst_o   = vid_rst_q;
  assign aud_skt_rst_o   = aud_rst_q;
  assign img_wt_o        = wt_q;
  assign img_ht_o        = ht_q;
  assign img_size_o      = size_q;
  assign vid_fps_o       = fps_q;
  assign line_blanking_o = blank_q;

endmodule
